// File: rtl/handshake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : handshake_pkg
// Description : Shared constants for the valid/ready pipeline slice: the MODE
//               encodings and the legal parameter ranges, plus the helper
//               functions used for elaboration-time parameter checking.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package handshake_pkg;

  // Register placement selected per stage
  localparam int MODE_BYPASS = 0;  // wires only, no state
  localparam int MODE_FWD    = 1;  // valid/data registered
  localparam int MODE_BWD    = 2;  // ready registered (skid buffer)
  localparam int MODE_FULL   = 3;  // valid/data and ready registered

  localparam int DATA_W_MIN = 1;
  localparam int DATA_W_MAX = 1024;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 8;

  function automatic bit mode_legal(input int mode);
    return (mode >= MODE_BYPASS) && (mode <= MODE_FULL);
  endfunction

  function automatic bit params_legal(input int data_w, input int stages, input int mode);
    return mode_legal(mode) &&
           (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) &&
           (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

endpackage : handshake_pkg
`default_nettype wire

// File: rtl/handshake_slice_stage.sv
`default_nettype none
// ============================================================================
// Module      : handshake_slice_stage
// Description : One valid/ready register stage. MODE picks which direction is
//               registered: FWD (valid/data, capacity 1), BWD (skid on the
//               ready path, capacity 1) or FULL (main + skid, capacity 2).
// Ports       : clk, rst_n            - clock, async active-low reset
//               in_valid_i/in_data_i  - upstream beat
//               in_ready_o            - stage accepts upstream beat
//               out_valid_o/out_data_o- downstream beat
//               out_ready_i           - downstream accepts beat
//               busy_o                - stage holds at least one beat
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_slice_stage
  import handshake_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MODE   = MODE_FWD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              busy_o
);

  if (MODE == MODE_FWD) begin : g_fwd
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              w_in_fire;
    logic              w_out_fire;

    // Ready is passed back combinationally; an empty register always accepts.
    assign in_ready_o = out_ready_i | ~vld_q;
    assign w_in_fire  = in_valid_i & in_ready_o;
    assign w_out_fire = vld_q & out_ready_i;

    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (w_in_fire) begin
        vld_d = 1'b1;
        dat_d = in_data_i;
      end else if (w_out_fire) begin
        vld_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign out_valid_o = vld_q;
    assign out_data_o  = dat_q;
    assign busy_o      = vld_q;

  end else if (MODE == MODE_BWD) begin : g_bwd
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_dat_q, skid_dat_d;

    // Upstream sees a registered ready; the skid absorbs the one beat that
    // can arrive in the cycle downstream stalls.
    assign in_ready_o  = ~skid_vld_q;
    assign out_valid_o = in_valid_i | skid_vld_q;
    assign out_data_o  = skid_vld_q ? skid_dat_q : in_data_i;

    always_comb begin
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      if (skid_vld_q) begin
        if (out_ready_i) begin
          skid_vld_d = 1'b0;
        end
      end else if (in_valid_i && !out_ready_i) begin
        skid_vld_d = 1'b1;
        skid_dat_d = in_data_i;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_vld_q <= 1'b0;
        skid_dat_q <= '0;
      end else begin
        skid_vld_q <= skid_vld_d;
        skid_dat_q <= skid_dat_d;
      end
    end

    assign busy_o = skid_vld_q;

  end else if (MODE == MODE_FULL) begin : g_full
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
    logic              w_in_fire;
    logic              w_main_load;

    assign in_ready_o  = ~skid_vld_q;
    assign w_in_fire   = in_valid_i & ~skid_vld_q;
    // Main register can take a new beat when empty or emptying this cycle
    assign w_main_load = ~vld_q | out_ready_i;

    always_comb begin
      vld_d      = vld_q;
      dat_d      = dat_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      if (w_main_load) begin
        // The skid beat is older than anything on the input, so it goes first.
        // While the skid is occupied in_ready is low, so no input competes.
        if (skid_vld_q) begin
          vld_d      = 1'b1;
          dat_d      = skid_dat_q;
          skid_vld_d = 1'b0;
        end else if (w_in_fire) begin
          vld_d = 1'b1;
          dat_d = in_data_i;
        end else begin
          vld_d = 1'b0;
        end
      end else if (w_in_fire) begin
        skid_vld_d = 1'b1;
        skid_dat_d = in_data_i;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q      <= 1'b0;
        dat_q      <= '0;
        skid_vld_q <= 1'b0;
        skid_dat_q <= '0;
      end else begin
        vld_q      <= vld_d;
        dat_q      <= dat_d;
        skid_vld_q <= skid_vld_d;
        skid_dat_q <= skid_dat_d;
      end
    end

    assign out_valid_o = vld_q;
    assign out_data_o  = dat_q;
    assign busy_o      = vld_q | skid_vld_q;

  end else begin : g_bad_mode
    $error("handshake_slice_stage: MODE %0d has no registered stage", MODE);
    assign in_ready_o  = 1'b0;
    assign out_valid_o = 1'b0;
    assign out_data_o  = '0;
    assign busy_o      = 1'b0;
  end

endmodule : handshake_slice_stage
`default_nettype wire

// File: rtl/handshake_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module      : handshake_pipe_slice
// Description : Parametrised valid/ready pipeline slice. Chains STAGES stages
//               of the selected MODE, or wires straight through for BYPASS.
//               Order, throughput and data integrity are preserved in every
//               mode.
// Ports       : clk, rst_n          - clock, async active-low reset
//               s_valid/s_data/s_ready - upstream (slave) side
//               m_valid/m_data/m_ready - downstream (master) side
//               busy                - any beat held inside the slice
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_pipe_slice
  import handshake_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 1,
  parameter int MODE   = MODE_FWD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy
);

  if (!params_legal(DATA_W, STAGES, MODE)) begin : g_param_check
    $error("handshake_pipe_slice: illegal parameters DATA_W=%0d STAGES=%0d MODE=%0d",
           DATA_W, STAGES, MODE);
  end

  if (MODE == MODE_BYPASS) begin : g_bypass
    logic w_unused_bypass;

    assign m_valid = s_valid;
    assign m_data  = s_data;
    assign s_ready = m_ready;
    assign busy    = 1'b0;
    // No state in this mode, so the clock and reset have no load
    assign w_unused_bypass = clk & rst_n;

  end else begin : g_pipe
    // Each stage owns its link wires; neighbours are reached by name so that
    // the ready chain is not one shared vector with bit-to-bit dependencies.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic              w_in_valid;
      logic [DATA_W-1:0] w_in_data;
      logic              w_in_ready;
      logic              w_out_valid;
      logic [DATA_W-1:0] w_out_data;
      logic              w_out_ready;
      logic              w_busy;
      logic              w_busy_acc;

      if (k == 0) begin : g_head
        assign w_in_valid = s_valid;
        assign w_in_data  = s_data;
        assign s_ready    = w_in_ready;
        assign w_busy_acc = w_busy;
      end else begin : g_link_in
        assign w_in_valid = g_stage[k-1].w_out_valid;
        assign w_in_data  = g_stage[k-1].w_out_data;
        assign w_busy_acc = w_busy | g_stage[k-1].w_busy_acc;
      end

      if (k == STAGES - 1) begin : g_tail
        assign w_out_ready = m_ready;
        assign m_valid     = w_out_valid;
        assign m_data      = w_out_data;
      end else begin : g_link_out
        assign w_out_ready = g_stage[k+1].w_in_ready;
      end

      handshake_slice_stage #(
        .DATA_W (DATA_W),
        .MODE   (MODE)
      ) u_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (w_in_valid),
        .in_data_i   (w_in_data),
        .in_ready_o  (w_in_ready),
        .out_valid_o (w_out_valid),
        .out_data_o  (w_out_data),
        .out_ready_i (w_out_ready),
        .busy_o      (w_busy)
      );
    end

    assign busy = g_stage[STAGES-1].w_busy_acc;
  end

endmodule : handshake_pipe_slice
`default_nettype wire

// File: tb/tb_handshake_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_pipe_slice
// Description : Self-checking bench. Four slices run side by side:
//               0 = BYPASS, 1 = FWD x3, 2 = BWD x1, 3 = FULL x2 (DATA_W = 8).
//               Directed scenarios with hand-derived expectations, then a
//               random stream per slice against an in-order scoreboard with
//               a hold-stable check on the downstream side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_pipe_slice;

  localparam int NB        = 10000;
  localparam int RND_BOUND = 80000;
  localparam int SB_DEPTH  = 16384;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      sv;
  logic [3:0]      sr;
  logic [3:0]      mv;
  logic [3:0]      mr;
  logic [3:0]      bsy;
  logic [3:0][7:0] sd;
  logic [3:0][7:0] md;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    handshake_pipe_slice #(
      .DATA_W (8),
      .STAGES ((g == 1) ? 3 : (g == 3) ? 2 : 1),
      .MODE   (g)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (sv[g]),
      .s_data  (sd[g]),
      .s_ready (sr[g]),
      .m_valid (mv[g]),
      .m_data  (md[g]),
      .m_ready (mr[g]),
      .busy    (bsy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Random-phase scoreboard state
  logic [7:0] sb [4][SB_DEPTH];
  int         wr [4];
  int         rd [4];
  int         offered [4];
  logic       acc [4];
  logic       stall_q [4];
  logic [7:0] held_q [4];

  initial begin
    int  n_acc;
    int  n_out;
    int  n_seen;
    bit  done;

    sv = '0; sd = '0; mr = '0;

    // ---------------- reset / idle ----------------
    cyc(); cyc();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_m_valid[%0d]", g), mv[g], 1'b0);
      chk($sformatf("rst_m_data[%0d]", g),  md[g], 8'h00);
      chk($sformatf("rst_busy[%0d]", g),    bsy[g], 1'b0);
    end
    for (int g = 1; g < 4; g++) chk($sformatf("rst_s_ready[%0d]", g), sr[g], 1'b1);
    chk("byp_s_ready_lo", sr[0], 1'b0);
    mr[0] = 1'b1; #1;
    chk("byp_s_ready_hi", sr[0], 1'b1);
    sv[0] = 1'b1; sd[0] = 8'h3C; #1;
    chk("byp_m_valid", mv[0], 1'b1);
    chk("byp_m_data",  md[0], 8'h3C);
    sv[0] = 1'b0; sd[0] = 8'h00; mr[0] = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // ---------------- FWD x3 streaming ----------------
    mr[1] = 1'b1; sv[1] = 1'b1; sd[1] = 8'd1;
    for (int c = 1; c <= 11; c++) begin
      cyc();
      if (c < 8) sd[1] = 8'(c + 1);
      else       sv[1] = 1'b0;
      #1;
      if (c < 3 || c == 11) begin
        chk($sformatf("fwd_m_valid_c%0d", c), mv[1], 1'b0);
      end else begin
        chk($sformatf("fwd_m_valid_c%0d", c), mv[1], 1'b1);
        chk($sformatf("fwd_m_data_c%0d", c),  md[1], 32'(c - 2));
      end
    end
    chk("fwd_busy_drained", bsy[1], 1'b0);
    mr[1] = 1'b0;

    // ---------------- BWD x1 skid ----------------
    mr[2] = 1'b0; sv[2] = 1'b1; sd[2] = 8'h55; #1;
    chk("bwd_s_ready_pre", sr[2], 1'b1);
    chk("bwd_m_data_comb", md[2], 8'h55);
    cyc();
    sv[2] = 1'b0; sd[2] = 8'h00; #1;
    chk("bwd_s_ready_skid", sr[2], 1'b0);
    chk("bwd_m_valid_skid", mv[2], 1'b1);
    chk("bwd_m_data_skid",  md[2], 8'h55);
    chk("bwd_busy_skid",    bsy[2], 1'b1);
    mr[2] = 1'b1; #1;
    chk("bwd_m_data_out", md[2], 8'h55);
    cyc();
    chk("bwd_s_ready_back", sr[2], 1'b1);
    chk("bwd_m_valid_empty", mv[2], 1'b0);
    chk("bwd_busy_empty", bsy[2], 1'b0);
    mr[2] = 1'b0;

    // ---------------- FULL x2 backpressure ----------------
    mr[3] = 1'b0; sv[3] = 1'b1; sd[3] = 8'hA0; n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      acc[3] = sv[3] & sr[3];
      cyc();
      if (acc[3]) begin
        n_acc++;
        sd[3] = 8'(8'hA0 + n_acc);
      end
    end
    chk("bp_accepted", n_acc, 4);
    chk("bp_s_ready", sr[3], 1'b0);
    chk("bp_m_valid", mv[3], 1'b1);
    chk("bp_m_data",  md[3], 8'hA0);
    chk("bp_busy",    bsy[3], 1'b1);
    mr[3] = 1'b1; n_out = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mv[3] & mr[3]) begin
        chk($sformatf("bp_order_%0d", n_out), md[3], 32'(8'hA0 + n_out));
        n_out++;
      end
      acc[3] = sv[3] & sr[3];
      cyc();
      if (acc[3]) begin
        n_acc++;
        if (n_acc < 8) sd[3] = 8'(8'hA0 + n_acc);
        else           sv[3] = 1'b0;
      end
    end
    chk("bp_out_count", n_out, 8);
    chk("bp_busy_drained", bsy[3], 1'b0);

    // ---------------- FULL x2 reset mid-stream ----------------
    mr[3] = 1'b0; sv[3] = 1'b1; sd[3] = 8'h11;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i < 2) sd[3] = 8'(8'h12 + i);
      else       sv[3] = 1'b0;
    end
    chk("mrst_busy_before", bsy[3], 1'b1);
    chk("mrst_m_valid_before", mv[3], 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_busy_async", bsy[3], 1'b0);
    chk("mrst_m_valid_async", mv[3], 1'b0);
    chk("mrst_m_data_async", md[3], 8'h00);
    cyc(); cyc();
    rst_n = 1'b1;
    mr[3] = 1'b1; n_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (mv[3]) n_seen++;
    end
    chk("mrst_no_old_beats", n_seen, 0);
    chk("mrst_s_ready", sr[3], 1'b1);

    // ---------------- random streams, all modes ----------------
    sv = '0; mr = '0;
    for (int g = 0; g < 4; g++) begin
      wr[g] = 0; rd[g] = 0; offered[g] = 0;
      acc[g] = 1'b0; stall_q[g] = 1'b0; held_q[g] = 8'h00;
    end
    done = 1'b0;
    for (int c = 0; c < RND_BOUND && !done; c++) begin
      cyc();
      for (int g = 0; g < 4; g++) begin
        // A new beat is only offered once the previous one was taken
        if (acc[g] || !sv[g]) begin
          if (offered[g] < NB && $urandom_range(0, 1) == 1) begin
            sv[g] = 1'b1;
            sd[g] = 8'($urandom);
            offered[g]++;
          end else begin
            sv[g] = 1'b0;
          end
        end
        mr[g] = 1'($urandom_range(0, 1));
      end
      #1;
      done = 1'b1;
      for (int g = 0; g < 4; g++) begin
        acc[g] = sv[g] & sr[g];
        if (acc[g]) begin
          sb[g][wr[g]] = sd[g];
          wr[g]++;
        end
        if (stall_q[g]) begin
          chk($sformatf("rnd_hold_valid[%0d]", g), mv[g], 1'b1);
          chk($sformatf("rnd_hold_data[%0d]", g),  md[g], held_q[g]);
        end
        if (mv[g] & mr[g]) begin
          chk($sformatf("rnd_beat_avail[%0d]", g), rd[g] < wr[g], 1'b1);
          if (rd[g] < wr[g]) begin
            chk($sformatf("rnd_data[%0d]#%0d", g, rd[g]), md[g], sb[g][rd[g]]);
            rd[g]++;
          end
        end
        stall_q[g] = mv[g] & ~mr[g];
        held_q[g]  = md[g];
        if (rd[g] != NB) done = 1'b0;
      end
    end
    chk("rnd_done", done, 1'b1);
    sv = '0;
    cyc();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rnd_in_count[%0d]", g),  wr[g], NB);
      chk($sformatf("rnd_out_count[%0d]", g), rd[g], NB);
      chk($sformatf("rnd_busy_end[%0d]", g),  bsy[g], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_handshake_pipe_slice
`default_nettype wire

// File: doc/handshake_pipe_slice.md
# handshake_pipe_slice

Parametrised valid/ready pipeline slice for breaking timing paths on streaming interfaces. It chains STAGES identical register stages. MODE selects what each stage registers: the forward (valid/data) path, the backward (ready) path, both, or neither. It sits between any two valid/ready endpoints in the datapath and preserves full throughput, ordering and data integrity in every mode.

## Interface
- DATA_W, 32, payload width in bits (1..1024)
- STAGES, 1, number of chained stages (1..8); ignored when MODE=BYPASS
- MODE, 1, 0=BYPASS, 1=FWD (valid/data registered), 2=BWD (ready registered, skid), 3=FULL (all registered)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  upstream data valid
- s_data  in  DATA_W  upstream payload
- s_ready  out  1  slice can accept s_data this cycle
- m_valid  out  1  downstream data valid
- m_data  out  DATA_W  downstream payload
- m_ready  in  1  downstream accepts this cycle
- busy  out  1  OR of all stage valid/skid flags (any beat held inside)

## Operation
- Transfer on a port occurs when valid & ready are both high at a rising edge. Beats leave in arrival order; none is dropped or duplicated.
- Upstream holds s_valid/s_data until accepted. The slice holds m_valid/m_data stable while m_valid & ~m_ready.
- BYPASS: m_valid=s_valid, m_data=s_data, s_ready=m_ready, busy=0. No state.
- FWD stage: one register `vld`/`dat`.
  - in_ready = out_ready | ~vld.
  - On in transfer: vld←1, dat←in_data.
  - Else on out transfer: vld←0.
  - Capacity 1.
- BWD stage (skid): registers `skid_vld`/`skid_dat`.
  - in_ready = ~skid_vld, driven directly from the register.
  - out_valid = in_valid | skid_vld.
  - out_data = skid_vld ? skid_dat : in_data.
  - In transfer with ~out_ready and ~skid_vld: capture into skid.
  - skid_vld & out_ready: skid_vld←0.
  - Capacity 1.
- FULL stage: a main register `vld`/`dat` plus a skid register. out_valid=vld, out_data=dat, in_ready=~skid_vld (registered).
  - When main is empty or draining, it takes skid data first, otherwise the input.
  - An input arriving while main stalls goes to skid.
  - Capacity 2.
- Stage k's out_* drive stage k+1's in_*. s_* connect to stage 0 and m_* to stage STAGES-1.
- Reset: every vld/skid_vld ← 0 and every data register ← 0. After reset m_valid=0, m_data=0, busy=0, and s_ready=1 (BYPASS: s_ready=m_ready).
- Reset asserted mid-stream discards all held beats immediately. The first cycle after deassertion behaves as the post-reset state.
- Simultaneous in and out transfer on a full FWD or FULL stage is legal and sustains one beat per cycle.

## Timing
- Latency s→m (first beat, m_ready=1): FWD STAGES cycles; FULL STAGES cycles; BWD 0 cycles (combinational data path); BYPASS 0.
- Throughput: 1 beat/cycle in all modes under continuous s_valid & m_ready.
- Combinational paths:
  - FWD: m_ready→s_ready only.
  - BWD: s_valid/s_data→m_valid/m_data only.
  - FULL: no input-to-output combinational path.
- Buffered beats after m_ready falls: FWD STAGES, BWD STAGES, FULL 2·STAGES. s_ready falls only when every stage is full.

## Structure
- Package handshake_pkg holds the MODE constants (MODE_BYPASS, MODE_FWD, MODE_BWD, MODE_FULL) and the parameter-range checks.
- Sub-module handshake_slice_stage implements one stage for a given MODE.
- The top is a generate loop of STAGES instances plus the BYPASS path and the busy OR-reduction.
- Illegal MODE or STAGES values trigger an elaboration-time error.

## Test plan
- Reset/idle, all modes: hold rst_n=0 → m_valid=0, m_data=0, busy=0, s_ready=1. BYPASS: s_ready tracks m_ready.
- Streaming: FWD, STAGES=3, s_valid=1 with data 1,2,3… and m_ready=1 → m_data=1 appears on cycle 3, then one beat per cycle, no gaps.
- Backpressure:
  - FULL, STAGES=2: m_ready=0 for 10 cycles while pushing 0xA0.. → exactly 4 beats accepted, then s_ready=0.
  - Release m_ready → 0xA0..0xA3 emitted in order.
- Skid: BWD, STAGES=1. Accept 0x55 with m_ready=0 → s_ready=0 next cycle, m_valid=1, m_data=0x55. Next cycle m_ready=1 → 0x55 transfers and s_ready returns to 1.
- Reset mid-operation: FULL, STAGES=2, 3 beats held, assert rst_n → busy=0 and m_valid=0 asynchronously. Old beats never appear afterwards.
- Random: constrained-random s_valid/m_ready (50%) over 10k beats, DATA_W=8, all modes → scoreboard sees an in-order exact match, and the hold-stable checker reports no violations.
